// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Single-outstanding word memory responder with a fixed request-to-response
//   latency. A request is accepted in IDLE. It waits LATENCY cycles (WAIT),
//   then presents a response (RESP) until the initiator consumes it.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-high reset (also clears the storage array)
//   req_valid    initiator presents a request
//   req_ready    responder can accept (IDLE and not in reset)
//   req_write    1 = write, 0 = read
//   req_address  byte address (must be word aligned and below WORDS*4)
//   req_wdata    write data
//   req_strobe   per-byte write enables
//   rsp_valid    response available
//   rsp_ready    initiator consumes the response
//   rsp_rdata    read data (0 for writes, errors and when no response)
//   rsp_error    misaligned or out-of-range request
module data_mem_responder #(
  parameter int WORDS   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_strobe,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int AW = $clog2(WORDS);
  localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state, next_state;
  logic [3:0]  cnt, next_cnt;

  logic        cap_write;
  logic [31:0] cap_address;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_strobe;

  logic [31:0] mem [WORDS];
  logic [31:0] rdata_q;
  logic        error_q;

  logic        accept;
  logic        enter_resp;
  logic        ex_write;
  logic [31:0] ex_address;
  logic [31:0] ex_wdata;
  logic [3:0]  ex_strobe;
  logic        ex_error;
  logic [AW-1:0] ex_index;

  // Ready depends only on the state register; it is also held low while reset
  // is asserted.
  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // The access runs on the edge that enters RESP. With LATENCY=1 that edge is
  // the accept edge itself, so the live request fields are used. Otherwise
  // the captured copy is used.
  always_comb begin
    ex_write   = cap_write;
    ex_address = cap_address;
    ex_wdata   = cap_wdata;
    ex_strobe  = cap_strobe;
    if (LATENCY == 1) begin
      ex_write   = req_write;
      ex_address = req_address;
      ex_wdata   = req_wdata;
      ex_strobe  = req_strobe;
    end
  end

  assign ex_error = (ex_address[1:0] != 2'b00) ||
                    ({2'b00, ex_address[31:2]} >= 32'(WORDS));
  assign ex_index = ex_address[AW+1:2];

  // Next-state and counter logic
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            next_state = RESP;
          end else begin
            next_state = WAIT;
            next_cnt   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          next_state = RESP;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = 4'd0;
      end
    endcase
  end

  assign enter_resp = (next_state == RESP) && (state != RESP);

  // State register and latency counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Request capture on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_write   <= 1'b0;
      cap_address <= 32'd0;
      cap_wdata   <= 32'd0;
      cap_strobe  <= 4'd0;
    end else if (accept) begin
      cap_write   <= req_write;
      cap_address <= req_address;
      cap_wdata   <= req_wdata;
      cap_strobe  <= req_strobe;
    end
  end

  // Response registers. They are loaded entering RESP and cleared when the
  // response is consumed. Read data samples the array before this edge's
  // write, but a read never writes anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 32'd0;
      error_q <= 1'b0;
    end else if (enter_resp) begin
      error_q <= ex_error;
      rdata_q <= (!ex_write && !ex_error) ? mem[ex_index] : 32'd0;
    end else if ((state == RESP) && rsp_ready) begin
      rdata_q <= 32'd0;
      error_q <= 1'b0;
    end
  end

  // Storage array. Byte-strobed writes happen only for legal addresses. It is
  // cleared on reset, so a write aborted by reset leaves no trace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (enter_resp && ex_write && !ex_error) begin
      for (int b = 0; b < 4; b++) begin
        if (ex_strobe[b]) begin
          mem[ex_index][8*b +: 8] <= ex_wdata[8*b +: 8];
        end
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
  assign rsp_error = rsp_valid && error_q;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter WORDS, 64, number of 32-bit words in the storage array; legal range is 2..1024, power of two.
REQ-002 Parameter LATENCY, 2, cycles from request accept to response valid; legal range is 1..15.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port req_valid  input  1  initiator presents a request.
REQ-006 Port req_ready  output  1  responder can accept a request.
REQ-007 Port req_write  input  1  1 selects a write, 0 selects a read.
REQ-008 Port req_address  input  32  byte address.
REQ-009 Port req_wdata  input  32  write data.
REQ-010 Port req_strobe  input  4  byte enables for a write; bit i maps to wdata[8i+7:8i].
REQ-011 Port rsp_valid  output  1  response available.
REQ-012 Port rsp_ready  input  1  initiator consumes the response.
REQ-013 Port rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-014 Port rsp_error  output  1  request was misaligned or out of range.

Function
REQ-015 FSM states SHALL be IDLE, WAIT and RESP; only one request is ever outstanding.
REQ-016 req_ready SHALL be 1 only in IDLE, as a registered function of state with no combinational path from req_valid.
REQ-017 Accept SHALL occur on an edge where req_valid and req_ready are both 1; req_write, req_address, req_wdata and req_strobe are captured at that edge.
REQ-018 On accept, the FSM SHALL go IDLE->RESP if LATENCY=1, else IDLE->WAIT with the down-counter loaded to LATENCY-2.
REQ-019 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL move to RESP on the edge where the counter is 0.
REQ-020 Accept at edge N SHALL give rsp_valid=1 in the cycle after edge N+LATENCY-1, i.e. exactly LATENCY cycles of req->rsp latency.
REQ-021 The storage write and the read-data capture SHALL both happen on the edge entering RESP; a read never observes its own cycle's write.
REQ-022 Error SHALL be flagged when captured address[1:0] != 0 or address[31:2] >= WORDS; then rsp_error=1, rsp_rdata=0, and no storage change.
REQ-023 A non-error write SHALL update only the bytes whose strobe bit is 1; strobe 4'b0000 is legal and is a no-op, with rsp_error=0.
REQ-024 A non-error read SHALL return the full addressed word; strobe is ignored.
REQ-025 In RESP, rsp_valid, rsp_rdata and rsp_error SHALL hold stable until rsp_ready=1, then the FSM SHALL go to IDLE on that edge.
REQ-026 rsp_valid SHALL deassert in the cycle after consumption; the earliest next accept is the edge after returning to IDLE (no same-cycle turnaround).
REQ-027 req_valid while not in IDLE SHALL be ignored, with no capture and no side effects.
REQ-028 rsp_rdata and rsp_error SHALL be 0 whenever rsp_valid=0.

Reset
REQ-029 Asserting rst SHALL immediately force: state IDLE, counter 0, req_ready 0 while rst=1, rsp_valid 0, rsp_rdata 0, rsp_error 0, all storage words 0.
REQ-030 req_ready SHALL become 1 in the first cycle after rst deasserts.
REQ-031 Reset during WAIT or RESP SHALL abort the request; a pending write is discarded and no response is issued.

Verification
REQ-032 LATENCY=2: write addr 0x08, data 0xDEADBEEF, strobe 4'hF -> rsp_valid exactly 2 cycles after accept, rsp_error=0; then read 0x08 -> rsp_rdata=0xDEADBEEF.
REQ-033 Partial write: word 0x10 holds 0x11223344; write 0xAABBCCDD with strobe 4'b0101 -> later read of 0x10 returns 0x11BB33DD.
REQ-034 Errors: read of 0x06 -> rsp_error=1, rsp_rdata=0; write to byte address WORDS*4 -> rsp_error=1 and a full-array readback is unchanged.
REQ-035 Backpressure: hold rsp_ready=0 for 5 cycles with a second req_valid asserted -> response stable throughout, req_ready=0, second request accepted only after return to IDLE.
REQ-036 LATENCY=1 and LATENCY=15 builds: read accept -> rsp_valid exactly 1 and 15 cycles later, respectively.
REQ-037 Assert rst mid-WAIT on a write to 0x04 -> outputs 0 asynchronously, and a post-reset read of 0x04 returns 0x00000000.
